viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators 7 and 5 octal) produced by the team's encoder. It sits directly downstream of the encoder, or of the channel model fed by it, and consumes the serial coded bit stream one bit per accepted cycle. It recovers the original information bits using a 4-state add-compare-select trellis and register-exchange survivor memory.

---
 rtl/viterbi_decoder_pkg.sv | 17 +
 rtl/viterbi_acs.sv | 28 ++
 rtl/viterbi_decoder.sv | 123 ++++++++++++
 tb/tb_viterbi_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_decoder_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 (7,5) Viterbi decoder.
// Holds the generator taps, trellis size and the per-branch expected coded pair.
package viterbi_decoder_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int NSTATES = 4;
  localparam int INIT_METRIC = 4;

  // Coded pair {g0,g1} emitted by the encoder in state (b1,b2) on input x.
  function automatic logic [1:0] expected_pair(input logic x, input logic b1, input logic b2);
    logic [2:0] taps;
    taps = {x, b1, b2};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: two saturating candidates, smaller wins,
// ties go to the predecessor with b2=0 (sel=0).
module viterbi_acs #(
  parameter int METRIC_W = 5
) (
  input  logic [METRIC_W-1:0] pm0,
  input  logic [METRIC_W-1:0] pm1,
  input  logic [1:0]          bm0,
  input  logic [1:0]          bm1,
  output logic                sel,
  output logic [METRIC_W-1:0] metric
);

  localparam logic [METRIC_W:0] MAX_SUM = {1'b0, {METRIC_W{1'b1}}};

  logic [METRIC_W:0]   sum0, sum1;
  logic [METRIC_W-1:0] cand0, cand1;

  always_comb begin
    sum0   = {1'b0, pm0} + {{(METRIC_W-1){1'b0}}, bm0};
    sum1   = {1'b0, pm1} + {{(METRIC_W-1){1'b0}}, bm1};
    cand0  = (sum0 > MAX_SUM) ? '1 : sum0[METRIC_W-1:0];
    cand1  = (sum1 > MAX_SUM) ? '1 : sum1[METRIC_W-1:0];
    sel    = (cand1 < cand0);
    metric = sel ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the (7,5) K=3 code.
// Pairs the serial coded stream, runs 4 ACS units, normalises and emits one bit per pair.
module viterbi_decoder
  import viterbi_decoder_pkg::*;
#(
  parameter int DEPTH    = 15,
  parameter int METRIC_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_start,
  output logic out_valid,
  output logic out_bit
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [DEPTH-1:0]    surv_t;

  localparam metric_t PM_INIT [NSTATES] =
    '{'0, metric_t'(INIT_METRIC), metric_t'(INIT_METRIC), metric_t'(INIT_METRIC)};

  logic             phase, g0_reg, pair_valid;
  logic [1:0]       pair;
  metric_t          pm [NSTATES];
  surv_t            surv [NSTATES];
  logic [CNT_W-1:0] pair_count;

  metric_t          acs_metric [NSTATES];
  logic             acs_sel [NSTATES];
  metric_t          norm_metric [NSTATES];
  surv_t            next_surv [NSTATES];
  metric_t          min01, min23, min_metric;
  logic [1:0]       best;
  logic [CNT_W-1:0] next_count;

  // Next state ns = {x,b1}; its predecessors are {b1,0} and {b1,1}.
  for (genvar ns = 0; ns < NSTATES; ns++) begin : g_state
    localparam logic X  = (ns >= 2);
    localparam logic B1 = (ns % 2 == 1);
    localparam int   P0 = (ns % 2) * 2;
    localparam int   P1 = P0 + 1;

    logic [1:0] d0, d1, bm0, bm1;

    assign d0  = pair ^ expected_pair(X, B1, 1'b0);
    assign d1  = pair ^ expected_pair(X, B1, 1'b1);
    assign bm0 = {1'b0, d0[1]} + {1'b0, d0[0]};
    assign bm1 = {1'b0, d1[1]} + {1'b0, d1[0]};

    viterbi_acs #(.METRIC_W(METRIC_W)) u_acs (
      .pm0   (pm[P0]),
      .pm1   (pm[P1]),
      .bm0   (bm0),
      .bm1   (bm1),
      .sel   (acs_sel[ns]),
      .metric(acs_metric[ns])
    );

    assign norm_metric[ns] = acs_metric[ns] - min_metric;
    assign next_surv[ns]   = acs_sel[ns] ? {surv[P1][DEPTH-2:0], X}
                                         : {surv[P0][DEPTH-2:0], X};
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    min01      = (acs_metric[1] < acs_metric[0]) ? acs_metric[1] : acs_metric[0];
    min23      = (acs_metric[3] < acs_metric[2]) ? acs_metric[3] : acs_metric[2];
    min_metric = (min23 < min01) ? min23 : min01;
    if (norm_metric[0] == '0)      best = 2'd0;
    else if (norm_metric[1] == '0) best = 2'd1;
    else if (norm_metric[2] == '0) best = 2'd2;
    else                           best = 2'd3;
    next_count = (pair_count == CNT_W'(DEPTH)) ? pair_count : pair_count + CNT_W'(1);
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  // NOTE: survivors are few small registers, not RAM, so they are reset like the metrics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      g0_reg     <= 1'b0;
      pair       <= '0;
      pair_valid <= 1'b0;
      pm         <= PM_INIT;
      surv       <= '{default: '0};
      pair_count <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
    end else if (in_start) begin
      // Frame restart beats both the incoming bit and any pair awaiting ACS.
      phase      <= 1'b0;
      pair_valid <= 1'b0;
      pm         <= PM_INIT;
      surv       <= '{default: '0};
      pair_count <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      out_valid  <= 1'b0;
      if (in_valid) begin
        phase <= ~phase;
        if (!phase) begin
          g0_reg <= in_bit;
        end else begin
          pair       <= {g0_reg, in_bit};
          pair_valid <= 1'b1;
        end
      end
      if (pair_valid) begin
        pm         <= norm_metric;
        surv       <= next_surv;
        pair_count <= next_count;
        out_valid  <= (next_count == CNT_W'(DEPTH));
        out_bit    <= next_surv[best][DEPTH-1];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench: encodes info bits with a behavioural (7,5) encoder, injects
// sparse errors and gaps, and expects the decoder to return the original bits.
module tb_viterbi_decoder;

  localparam int DEPTH    = 15;
  localparam int METRIC_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_start = 1'b0;
  logic out_valid, out_bit;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_outs = 0;
  int first_cyc = -1;
  int last_accept = 0;
  bit prev_valid = 1'b0;
  bit exp_q[$];
  bit info[];
  bit [1:0] err[];

  viterbi_decoder #(.DEPTH(DEPTH), .METRIC_W(METRIC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_start (in_start),
    .out_valid(out_valid),
    .out_bit  (out_bit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // Output monitor: every strobe must be isolated and carry the next expected info bit.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("strobe_width", 32'(prev_valid), 32'd0);
      check("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_bit", 32'(out_bit), 32'(exp_q.pop_front()));
      if (first_cyc < 0) first_cyc = cyc;
      frame_outs++;
    end
    prev_valid = rst_n && out_valid;
  end

  task automatic send_bit(input bit b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    last_accept = cyc;
    in_valid = 1'b0;
  endtask

  task automatic set_fixed(input int n);
    info = new[n];
    err  = new[n];
    foreach (info[k]) begin
      info[k] = 1'b0;
      err[k]  = 2'b00;
    end
    info[0] = 1; info[1] = 0; info[2] = 1; info[3] = 1; info[4] = 0; info[5] = 0;
  endtask

  task automatic set_random(input int n, input int n_rand, input bit with_err);
    info = new[n];
    err  = new[n];
    foreach (info[k]) begin
      info[k] = (k < n_rand) ? 1'($urandom) : 1'b0;
      err[k]  = (with_err && k % (3 * DEPTH) == 22 && k < n - 2 * DEPTH)
                ? 2'($urandom_range(1, 2)) : 2'b00;
    end
  endtask

  // One frame: in_start (with a junk bit that must be dropped), then n encoded pairs.
  task automatic run_frame(input int n, input bit gaps, input bit settle, input int abort_at);
    bit b1 = 1'b0;
    bit b2 = 1'b0;
    bit x, g0, g1;
    int acc = -1;
    in_start = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'($urandom);
    @(posedge clk); #1;
    in_start = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    frame_outs = 0;
    first_cyc  = -1;
    for (int k = 0; k < n; k++) exp_q.push_back(info[k]);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_bit", 32'(out_bit), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        rst_n = 1'b1;
        return;
      end
      x  = info[k];
      g0 = x ^ b1 ^ b2 ^ err[k][1];
      g1 = x ^ b2 ^ err[k][0];
      send_bit(g0, gaps);
      send_bit(g1, gaps);
      if (k == DEPTH - 1) acc = last_accept;
      b2 = b1;
      b1 = x;
    end
    if (settle) begin
      repeat (4) @(posedge clk);
      #1;
      check("frame_out_count", 32'(frame_outs), (n >= DEPTH) ? 32'(n - DEPTH + 1) : 32'd0);
      if (n >= DEPTH) check("first_out_latency", 32'(first_cyc), 32'(acc + 1));
    end
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_out_bit", 32'(out_bit), 32'd0);
    end

    set_fixed(DEPTH + 6);
    run_frame(DEPTH + 6, 1'b0, 1'b1, -1);

    err[2] = 2'b10;
    run_frame(DEPTH + 6, 1'b0, 1'b1, -1);

    err[2] = 2'b00;
    run_frame(DEPTH + 6, 1'b1, 1'b1, -1);

    // Abandoned frame: restart lands while its last pair is still pending.
    set_random(7, 7, 1'b0);
    run_frame(7, 1'b0, 1'b0, -1);
    check("old_frame_outs", 32'(frame_outs), 32'd0);
    set_fixed(DEPTH + 6);
    run_frame(DEPTH + 6, 1'b0, 1'b1, -1);

    set_random(10000 + DEPTH + 5, 10000, 1'b1);
    run_frame(10000 + DEPTH + 5, 1'b0, 1'b1, -1);

    set_random(40, 40, 1'b0);
    run_frame(40, 1'b0, 1'b0, 30);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_reset_out_valid", 32'(out_valid), 32'd0);
      check("post_reset_out_bit", 32'(out_bit), 32'd0);
    end
    set_random(DEPTH + 10, DEPTH + 10, 1'b0);
    run_frame(DEPTH + 10, 1'b1, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
